// File: rtl/nibble_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract sequencer: one nibble per cycle through a
// single 4-bit ripple-carry adder, LSB first, with valid/ready on both sides.
module nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is a pure function of state; out_valid is registered
  // and, once high, holds with stable sum/cout/ovf until out_ready is sampled.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_nib_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic             r_msb_a;
  logic             r_msb_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_b_in;
  logic [3:0]       w_nib_s;
  logic             w_nib_co;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
  assign w_b_in     = sub ? ~b : b;
  assign w_sum_next = {w_nib_s, r_sum[WIDTH-1:4]};
  assign w_last     = (r_nib_cnt == CNT_W'(NIB - 1));

  RCA_4bit u_rca (
    .a  (r_a[3:0]),
    .b  (r_b[3:0]),
    .ci (r_c),
    .s  (w_nib_s),
    .co (w_nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_nib_cnt   <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_msb_a     <= 1'b0;
      r_msb_b     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= w_b_in;
            r_c       <= cin ^ sub;
            r_msb_a   <= a[WIDTH-1];
            r_msb_b   <= w_b_in[WIDTH-1];
            r_nib_cnt <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_a       <= r_a >> 4;
          r_b       <= r_b >> 4;
          r_sum     <= w_sum_next;
          r_c       <= w_nib_co;
          r_nib_cnt <= r_nib_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_cout      <= w_nib_co;
            // Signed overflow: same-sign operands produced a different-sign result.
            r_ovf       <= (r_msb_a == r_msb_b) && (w_nib_s[3] != r_msb_a);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// 4-bit ripple-carry adder built from full-adder cells.
module RCA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[4];

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Self-checking bench for nibble_seq_adder (WIDTH=16): directed vectors,
// backpressure, mid-run reset and a randomised run against a reference model.
module tb_nibble_seq_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_vec;
  int n_err;
  int n_acc;
  int n_res;
  int lat;

  logic [W+1:0] exp_q[$];

  nibble_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: WIDTH+1-bit arithmetic, returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tc, input logic ts);
    logic [W:0] r;
    logic       ov;
    if (!ts) begin
      r  = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      ov = (ta[W-1] == tb[W-1]) && (r[W-1] != ta[W-1]);
    end else begin
      // a - b - cin; carry out 1 means no borrow occurred.
      r  = {1'b1, ta} - {1'b0, tb} - {{W{1'b0}}, tc};
      ov = (ta[W-1] != tb[W-1]) && (r[W-1] != ta[W-1]);
    end
    return {ov, r[W], r[W-1:0]};
  endfunction

  // Driver: wait for in_ready, present one operand pair, scramble inputs after accept.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta; b = tb; cin = tc; sub = ts;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    exp_q.push_back(model(ta, tb, tc, ts));
    n_acc++;
  endtask

  task automatic wait_out();
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_res++;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input logic [W-1:0] e_sum,
                          input logic e_cout, input logic e_ovf);
    send(ta, tb, tc, ts, 0);
    wait_out();
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    take();
    check({tag, "_vld_fall"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W+1:0] exp_v;
    int           g_in;
    int           g_out;
    n_vec = 0; n_err = 0; n_acc = 0; n_res = 0; lat = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state, observed while reset is held
    rst_n = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic vectors
    directed("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    directed("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("add_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_cin",    16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Backpressure: DONE holds for 10 cycles while inputs toggle
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      check("bp_hold", {14'd0, ovf, cout, sum}, {14'd0, 2'b00, 16'h2233});
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    take();
    check("bp_vld_fall", 32'(out_valid), 32'd0);
    check("bp_rdy_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_no_accept", 32'(dbg_state), 32'd0);

    // Reset mid-RUN, asserted mid-cycle after two RUN edges
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Randomised run with input/output gaps against the reference model
    n_acc = 0; n_res = 0;
    exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      g_in  = $urandom_range(0, 3);
      g_out = $urandom_range(0, 3);
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), g_in);
      wait_out();
      repeat (g_out) begin
        @(posedge clk);
        #1;
      end
      if (exp_q.size() == 0) begin
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_v = exp_q[0];
        check("rnd_result", {14'd0, ovf, cout, sum}, {14'd0, exp_v});
      end
      take();
    end
    check("rnd_count", 32'(n_res), 32'(n_acc));
    check("rnd_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
